// File: rtl/vec_decode_pkg.sv
// Shared types and the opcode decoder for the vector decode stage.
// Holds the opcode and register-type enums, the width-independent control part of the decoded
// bundle, and decode_fields(), which maps {funct, opcode} to register types and source usage.
package vec_decode_pkg;

  typedef enum logic [2:0] {
    OpMovImm  = 3'b000,
    OpMovSv   = 3'b001,
    OpAddi    = 3'b010,
    OpSubi    = 3'b011,
    OpMul     = 3'b100,
    OpAdd     = 3'b101,
    OpDiv     = 3'b110,
    OpIllegal = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    RT_NOP = 2'b00,
    RT_VS  = 2'b01,
    RT_S   = 2'b10,
    RT_VV  = 2'b11
  } reg_type_e;

  // Control half of the decoded bundle. The operand fields themselves are parameter-sized and are
  // carried by the stage; src1 comes from oper1 or oper2, src2 is always oper3.
  typedef struct packed {
    reg_type_e rt;
    logic      dst_vec;
    logic      illegal;
    logic      src1_en;
    logic      src1_from_oper2;
    logic      src1_vec;
    logic      src2_en;
    logic      src2_vec;
  } decode_ctrl_t;

  function automatic decode_ctrl_t decode_fields(input logic funct, input logic [2:0] opcode);
    decode_ctrl_t d;
    d.rt              = RT_NOP;
    d.dst_vec         = 1'b0;
    d.illegal         = 1'b0;
    d.src1_en         = 1'b0;
    d.src1_from_oper2 = 1'b0;
    d.src1_vec        = 1'b0;
    d.src2_en         = 1'b0;
    d.src2_vec        = 1'b0;
    if (funct) begin
      // Load/store overrides the opcode, including 111.
      d.rt              = RT_VS;
      d.dst_vec         = 1'b1;
      d.src1_en         = 1'b1;
      d.src1_from_oper2 = 1'b1;
    end else begin
      unique case (opcode_e'(opcode))
        OpMovImm: d.rt = RT_S;
        OpMovSv: begin
          d.rt      = RT_S;
          d.dst_vec = 1'b1;
          d.src1_en = 1'b1;
        end
        OpAddi, OpSubi: begin
          d.rt      = RT_S;
          d.src1_en = 1'b1;
        end
        OpMul, OpDiv: begin
          d.rt              = RT_VS;
          d.dst_vec         = 1'b1;
          d.src1_en         = 1'b1;
          d.src1_from_oper2 = 1'b1;
          d.src1_vec        = 1'b1;
          d.src2_en         = 1'b1;
        end
        OpAdd: begin
          d.rt              = RT_VV;
          d.dst_vec         = 1'b1;
          d.src1_en         = 1'b1;
          d.src1_from_oper2 = 1'b1;
          d.src1_vec        = 1'b1;
          d.src2_en         = 1'b1;
          d.src2_vec        = 1'b1;
        end
        OpIllegal: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/vector_decode_stage_scoreboard.sv
// Pending-write scoreboard for the scalar and vector register files.
// Ports: clk, rst (async, active-high); set_en/set_vec/set_addr marks a register pending;
// clr_en/clr_vec/clr_addr clears one (a set of the same bit in the same cycle wins);
// q1_*/q2_* are two source queries; busy is high when any enabled query hits a pending bit.
// Vector indices use the low VREG_AW bits of an address. Scalar register 0 is never pending.
module vec_scoreboard #(
  parameter int unsigned SREG_AW = 4,
  parameter int unsigned VREG_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic               set_vec,
  input  logic [SREG_AW-1:0] set_addr,
  input  logic               clr_en,
  input  logic               clr_vec,
  input  logic [SREG_AW-1:0] clr_addr,
  input  logic               q1_en,
  input  logic               q1_vec,
  input  logic [SREG_AW-1:0] q1_addr,
  input  logic               q2_en,
  input  logic               q2_vec,
  input  logic [SREG_AW-1:0] q2_addr,
  output logic               busy
);

  localparam int unsigned NumSreg = 2 ** SREG_AW;
  localparam int unsigned NumVreg = 2 ** VREG_AW;

  logic [NumSreg-1:0] spend_q, spend_d;
  logic [NumVreg-1:0] vpend_q, vpend_d;
  logic               q1_hit, q2_hit;

  always_comb begin
    spend_d = spend_q;
    vpend_d = vpend_q;
    if (clr_en) begin
      if (clr_vec) vpend_d[clr_addr[VREG_AW-1:0]] = 1'b0;
      else         spend_d[clr_addr] = 1'b0;
    end
    // Applied after the clear so a simultaneous set takes priority.
    if (set_en) begin
      if (set_vec) vpend_d[set_addr[VREG_AW-1:0]] = 1'b1;
      else         spend_d[set_addr] = 1'b1;
    end
    spend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spend_q <= '0;
      vpend_q <= '0;
    end else begin
      spend_q <= spend_d;
      vpend_q <= vpend_d;
    end
  end

  always_comb begin
    q1_hit = q1_vec ? vpend_q[q1_addr[VREG_AW-1:0]] : spend_q[q1_addr];
    q2_hit = q2_vec ? vpend_q[q2_addr[VREG_AW-1:0]] : spend_q[q2_addr];
    busy   = (q1_en && q1_hit) || (q2_en && q2_hit);
  end

endmodule

// File: rtl/vector_decode_stage.sv
// Registered decode stage between fetch and execute of the vector processor.
// Splits an instruction {funct, opcode, imm_flag, wb[1:0], oper1, oper2, oper3, ...} (imm in the
// low IMM_W bits) into EX/MEM/WB control, operand indices, immediate and register-type flags.
// Ports: clk, rst (async, active-high); in_valid/in_instr/in_ready fetch handshake;
// out_valid/out_ready execute handshake; flush drops the held bundle; ex_ctrl, mem_ctrl, wb_ctrl,
// oper1..3, imm, reg_type, des_type, illegal form the bundle; wb_valid/wb_is_vec/wb_addr retire a
// pending write. RAW hazards stall in_ready until the writer's writeback.
// Optional: DECODE_PERF_CNT_EN adds saturating 32-bit stall_cnt and issue_cnt outputs.
module vector_decode_stage
  import vec_decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 21,  // must be >= 7 + SREG_AW + 2*VREG_AW
  parameter int unsigned SREG_AW = 4,
  parameter int unsigned VREG_AW = 3,
  parameter int unsigned IMM_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [4:0]         ex_ctrl,
  output logic [3:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic [SREG_AW-1:0] oper1,
  output logic [VREG_AW-1:0] oper2,
  output logic [VREG_AW-1:0] oper3,
  output logic [IMM_W-1:0]   imm,
  output logic [1:0]         reg_type,
  output logic               des_type,
  output logic               illegal,
  input  logic               wb_valid,
  input  logic               wb_is_vec,
  input  logic [SREG_AW-1:0] wb_addr
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        issue_cnt
`endif
);

  localparam int unsigned O1Hi = INSTR_W - 8;
  localparam int unsigned O1Lo = INSTR_W - 7 - SREG_AW;
  localparam int unsigned O2Lo = O1Lo - VREG_AW;
  localparam int unsigned O3Lo = O2Lo - VREG_AW;

  // Instruction fields
  logic               f_funct, f_immf;
  logic [2:0]         f_op;
  logic [1:0]         f_wb;
  logic [SREG_AW-1:0] f_oper1;
  logic [VREG_AW-1:0] f_oper2, f_oper3;
  decode_ctrl_t       dc;

  assign f_funct = in_instr[INSTR_W-1];
  assign f_op    = in_instr[INSTR_W-2 -: 3];
  assign f_immf  = in_instr[INSTR_W-5];
  assign f_wb    = in_instr[INSTR_W-6 -: 2];
  assign f_oper1 = in_instr[O1Hi:O1Lo];
  assign f_oper2 = in_instr[O1Lo-1:O2Lo];
  assign f_oper3 = in_instr[O2Lo-1:O3Lo];
  assign dc      = decode_fields(f_funct, f_op);

  // Held bundle
  logic               out_valid_q;
  logic [4:0]         ex_ctrl_q, ex_ctrl_d;
  logic [3:0]         mem_ctrl_q, mem_ctrl_d;
  logic [1:0]         wb_ctrl_q, wb_ctrl_d;
  logic [SREG_AW-1:0] oper1_q, oper1_d;
  logic [VREG_AW-1:0] oper2_q, oper2_d, oper3_q, oper3_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  reg_type_e          reg_type_q;
  logic               des_type_q, illegal_q;

  // Legal instructions carry their fields through; an illegal one is a NOP with all fields 0.
  always_comb begin
    ex_ctrl_d  = {f_funct, f_op, f_immf};
    mem_ctrl_d = {f_funct, f_op};
    wb_ctrl_d  = f_wb;
    oper1_d    = f_oper1;
    oper2_d    = f_oper2;
    oper3_d    = f_oper3;
    imm_d      = in_instr[IMM_W-1:0];
    if (dc.illegal) begin
      ex_ctrl_d  = '0;
      mem_ctrl_d = '0;
      wb_ctrl_d  = '0;
      oper1_d    = '0;
      oper2_d    = '0;
      oper3_d    = '0;
      imm_d      = '0;
    end
  end

  // Source operands of the incoming instruction
  logic [SREG_AW-1:0] src1_addr, src2_addr;
  assign src1_addr = dc.src1_from_oper2 ? SREG_AW'(f_oper2) : f_oper1;
  assign src2_addr = SREG_AW'(f_oper3);

  // Held bundle still owes a write that the scoreboard does not know about yet.
  logic held_wr, m1, m2, sb_busy, hazard, accept, xfer;
  assign held_wr = out_valid_q && wb_ctrl_q[0] && (des_type_q || (oper1_q != '0));

  always_comb begin
    m1 = dc.src1_en && held_wr && (dc.src1_vec == des_type_q) &&
         (dc.src1_vec ? (src1_addr[VREG_AW-1:0] == oper1_q[VREG_AW-1:0]) : (src1_addr == oper1_q));
    m2 = dc.src2_en && held_wr && (dc.src2_vec == des_type_q) &&
         (dc.src2_vec ? (src2_addr[VREG_AW-1:0] == oper1_q[VREG_AW-1:0]) : (src2_addr == oper1_q));
  end

  vec_scoreboard #(
    .SREG_AW (SREG_AW),
    .VREG_AW (VREG_AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (xfer && wb_ctrl_q[0]),
    .set_vec  (des_type_q),
    .set_addr (oper1_q),
    .clr_en   (wb_valid),
    .clr_vec  (wb_is_vec),
    .clr_addr (wb_addr),
    .q1_en    (dc.src1_en),
    .q1_vec   (dc.src1_vec),
    .q1_addr  (src1_addr),
    .q2_en    (dc.src2_en),
    .q2_vec   (dc.src2_vec),
    .q2_addr  (src2_addr),
    .busy     (sb_busy)
  );

  assign hazard   = sb_busy || m1 || m2;
  assign in_ready = !rst && (!out_valid_q || out_ready) && !(in_valid && hazard) && !flush;
  assign accept   = in_valid && in_ready;
  // A flushed bundle never counts as transferred, so its write is never marked pending.
  assign xfer     = out_valid_q && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= '0;
      wb_ctrl_q   <= '0;
      oper1_q     <= '0;
      oper2_q     <= '0;
      oper3_q     <= '0;
      imm_q       <= '0;
      reg_type_q  <= RT_NOP;
      des_type_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (flush)          out_valid_q <= 1'b0;
      else if (accept)    out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        ex_ctrl_q  <= ex_ctrl_d;
        mem_ctrl_q <= mem_ctrl_d;
        wb_ctrl_q  <= wb_ctrl_d;
        oper1_q    <= oper1_d;
        oper2_q    <= oper2_d;
        oper3_q    <= oper3_d;
        imm_q      <= imm_d;
        reg_type_q <= dc.rt;
        des_type_q <= dc.dst_vec;
        illegal_q  <= dc.illegal;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign oper1     = oper1_q;
  assign oper2     = oper2_q;
  assign oper3     = oper3_q;
  assign imm       = imm_q;
  assign reg_type  = reg_type_q;
  assign des_type  = des_type_q;
  assign illegal   = out_valid_q && illegal_q;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, issue_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (in_valid && hazard && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (xfer && (issue_cnt_q != '1))               issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule
